// File: rtl/ascon_decrypt_top.sv
// ASCON-AEAD128 decryption core: one permutation round per cycle on a single
// 320-bit state, plaintext released per block, tag recomputed and compared at the end.
module ascon_decrypt_top (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] data_i,
  input  logic         data_valid_i,
  input  logic         data_last_i,
  input  logic [4:0]   data_bytes_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] tag_i,
  output logic [127:0] plain_o,
  output logic         plain_valid_o,
  output logic [127:0] tag_o,
  output logic         auth_ok_o,
  output logic         end_o
);

  localparam logic [63:0] IV = 64'h00001000808c0001;

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD_PERM, WAIT_C, C_PERM, FINAL, DONE
  } state_t;

  state_t       state_reg;
  logic [319:0] s_reg;
  logic [3:0]   round_reg;
  logic         ad_last_reg;
  logic [127:0] plain_reg;
  logic         plain_valid_reg;
  logic [127:0] tag_reg;
  logic         auth_reg;
  logic         end_reg;

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[63:0];
    x1 = s[127:64];
    x2 = s[191:128];
    x3 = s[255:192];
    x4 = s[319:256];
    x2 = x2 ^ {56'b0, 4'd15 - i, i};
    // Bitsliced 5-bit S-box
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  logic [319:0] round_out;
  logic         last_round;
  logic [127:0] rate;
  logic [127:0] byte_mask;
  logic [128:0] pad;
  logic [319:0] s_last_c;
  logic [127:0] tag_calc;

  assign round_out  = ascon_round(s_reg, round_reg);
  assign last_round = (round_reg == 4'd11);
  assign rate       = s_reg[127:0];

  // Byte gi of the last ciphertext block is valid when gi < data_bytes_i
  for (genvar gi = 0; gi < 16; gi++) begin : g_mask
    assign byte_mask[8*gi +: 8] = (data_bytes_i > 5'(gi)) ? 8'hff : 8'h00;
  end

  assign pad = 129'(1) << (8 * data_bytes_i);

  // Last ciphertext absorb: splice valid bytes, pad at bit 8l, then key into x2/x3
  always_comb begin
    s_last_c            = {s_reg[319:128], (data_i & byte_mask) | (rate & ~byte_mask)};
    s_last_c[128:0]     = s_last_c[128:0] ^ pad;
    s_last_c[191:128]   = s_last_c[191:128] ^ key_i[63:0];
    s_last_c[255:192]   = s_last_c[255:192] ^ key_i[127:64];
  end

  assign tag_calc = {round_out[319:256] ^ key_i[127:64], round_out[255:192] ^ key_i[63:0]};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      s_reg           <= '0;
      round_reg       <= '0;
      ad_last_reg     <= 1'b0;
      plain_reg       <= '0;
      plain_valid_reg <= 1'b0;
      tag_reg         <= '0;
      auth_reg        <= 1'b0;
      end_reg         <= 1'b0;
    end else begin
      plain_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start_i) begin
            s_reg     <= {nonce_i[127:64], nonce_i[63:0], key_i[127:64], key_i[63:0], IV};
            round_reg <= 4'd0;
            end_reg   <= 1'b0;
            auth_reg  <= 1'b0;
            state_reg <= INIT;
          end
        end
        INIT: begin
          if (last_round) begin
            s_reg     <= round_out ^ {key_i, 192'b0};
            state_reg <= WAIT_AD;
          end else begin
            s_reg     <= round_out;
            round_reg <= round_reg + 4'd1;
          end
        end
        WAIT_AD: begin
          if (data_valid_i) begin
            s_reg[127:0] <= rate ^ data_i;
            ad_last_reg  <= data_last_i;
            round_reg    <= 4'd4;
            state_reg    <= AD_PERM;
          end
        end
        AD_PERM: begin
          if (last_round) begin
            // Domain separation between AD and ciphertext phases
            s_reg     <= round_out ^ {ad_last_reg, 319'b0};
            state_reg <= ad_last_reg ? WAIT_C : WAIT_AD;
          end else begin
            s_reg     <= round_out;
            round_reg <= round_reg + 4'd1;
          end
        end
        WAIT_C: begin
          if (data_valid_i) begin
            plain_valid_reg <= 1'b1;
            if (data_last_i) begin
              plain_reg <= (data_i ^ rate) & byte_mask;
              s_reg     <= s_last_c;
              round_reg <= 4'd0;
              state_reg <= FINAL;
            end else begin
              plain_reg    <= data_i ^ rate;
              s_reg[127:0] <= data_i;
              round_reg    <= 4'd4;
              state_reg    <= C_PERM;
            end
          end
        end
        C_PERM: begin
          s_reg <= round_out;
          if (last_round) state_reg <= WAIT_C;
          else            round_reg <= round_reg + 4'd1;
        end
        FINAL: begin
          s_reg <= round_out;
          if (last_round) begin
            tag_reg   <= tag_calc;
            auth_reg  <= (tag_calc == tag_i);
            end_reg   <= 1'b1;
            state_reg <= DONE;
          end else begin
            round_reg <= round_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign plain_o       = plain_reg;
  assign plain_valid_o = plain_valid_reg;
  assign tag_o         = tag_reg;
  assign auth_ok_o     = auth_reg;
  assign end_o         = end_reg;

endmodule

// File: tb/tb_ascon_decrypt_top.sv
// Randomized bench for ascon_decrypt_top: a word-level ASCON encryption model produces
// ciphertext and tags from known plaintext; one compare process checks outputs every cycle.
module tb_ascon_decrypt_top;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] data_i = '0;
  logic         data_valid_i = 1'b0;
  logic         data_last_i = 1'b0;
  logic [4:0]   data_bytes_i = '0;
  logic [127:0] key_i = '0;
  logic [127:0] nonce_i = '0;
  logic [127:0] tag_i = '0;
  logic [127:0] plain_o;
  logic         plain_valid_o;
  logic [127:0] tag_o;
  logic         auth_ok_o;
  logic         end_o;

  ascon_decrypt_top dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_last_i(data_last_i), .data_bytes_i(data_bytes_i),
    .key_i(key_i), .nonce_i(nonce_i), .tag_i(tag_i), .plain_o(plain_o),
    .plain_valid_o(plain_valid_o), .tag_o(tag_o), .auth_ok_o(auth_ok_o), .end_o(end_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  localparam logic [63:0] IV = 64'h00001000808c0001;
  localparam int BIG = 1 << 30;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  // Message description and model results
  logic [127:0] ad_blk [4];
  logic [127:0] pt_blk [4];
  logic [127:0] ct_blk [4];
  logic [127:0] exp_pt [4];
  logic [127:0] m_tag;
  logic [127:0] cur_key, cur_nonce;
  int n_ad, n_ct, last_len;

  // Expectations shared with the compare process
  typedef struct {int c; logic [127:0] d;} exp_t;
  exp_t pq [$];
  int end_cyc = BIG;
  int rst_cyc = -1;
  logic [127:0] exp_tag = '0;
  logic exp_auth = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Permutation from the round description: table S-box applied column by column
  function automatic logic [319:0] m_perm(input logic [319:0] s, input int first);
    logic [63:0] x [5];
    logic [4:0] col, o;
    for (int k = 0; k < 5; k++) x[k] = s[64*k +: 64];
    for (int r = first; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[col];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      x[0] = x[0] ^ m_ror(x[0], 19) ^ m_ror(x[0], 28);
      x[1] = x[1] ^ m_ror(x[1], 61) ^ m_ror(x[1], 39);
      x[2] = x[2] ^ m_ror(x[2], 1)  ^ m_ror(x[2], 6);
      x[3] = x[3] ^ m_ror(x[3], 10) ^ m_ror(x[3], 17);
      x[4] = x[4] ^ m_ror(x[4], 7)  ^ m_ror(x[4], 41);
    end
    return {x[4], x[3], x[2], x[1], x[0]};
  endfunction

  // Encrypt pt_blk to ct_blk; expected plaintext is the masked original
  task automatic model_encrypt();
    logic [319:0] s;
    logic [127:0] mask, c;
    s = {cur_nonce, cur_key, IV};
    s = m_perm(s, 0);
    s[255:192] ^= cur_key[63:0];
    s[319:256] ^= cur_key[127:64];
    for (int i = 0; i < n_ad; i++) begin
      s[127:0] ^= ad_blk[i];
      s = m_perm(s, 4);
      if (i == n_ad - 1) s[319] ^= 1'b1;
    end
    for (int i = 0; i < n_ct; i++) begin
      if (i < n_ct - 1) begin
        c = pt_blk[i] ^ s[127:0];
        ct_blk[i] = c;
        exp_pt[i] = pt_blk[i];
        s[127:0] = c;
        s = m_perm(s, 4);
      end else begin
        mask = '0;
        for (int j = 0; j < last_len; j++) mask[8*j +: 8] = 8'hff;
        c = ((pt_blk[i] ^ s[127:0]) & mask) | (rnd128() & ~mask);
        ct_blk[i] = c;
        exp_pt[i] = pt_blk[i] & mask;
        s[127:0] = (c & mask) | (s[127:0] & ~mask);
        s[8*last_len] ^= 1'b1;
        s[191:128] ^= cur_key[63:0];
        s[255:192] ^= cur_key[127:64];
        s = m_perm(s, 0);
        m_tag = {s[319:256] ^ cur_key[127:64], s[255:192] ^ cur_key[63:0]};
      end
    end
  endtask

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, act, req);
    end
  endtask

  // Single compare process
  initial begin
    bit exp_v, exp_end;
    chk(m_ror(64'h1, 1) == 64'h8000000000000000, "model_ror1", m_ror(64'h1, 1), 128'h8000000000000000);
    chk(m_ror(64'h100, 8) == 64'h1, "model_ror8", m_ror(64'h100, 8), 128'h1);
    forever begin
      @(negedge clock_i);
      if (reset_i) continue;
      while (pq.size() > 0 && pq[0].c < cyc) void'(pq.pop_front());
      exp_v = (pq.size() > 0 && pq[0].c == cyc);
      chk(plain_valid_o === exp_v, "plain_valid", 128'(plain_valid_o), 128'(exp_v));
      if (exp_v) begin
        chk(plain_o === pq[0].d, "plain", plain_o, pq[0].d);
        void'(pq.pop_front());
      end
      exp_end = (cyc >= end_cyc);
      chk(end_o === exp_end, "end", 128'(end_o), 128'(exp_end));
      if (exp_end) begin
        chk(tag_o === exp_tag, "tag", tag_o, exp_tag);
        chk(auth_ok_o === exp_auth, "auth_ok", 128'(auth_ok_o), 128'(exp_auth));
      end
      if (cyc == rst_cyc) begin
        chk(plain_o === '0, "reset_plain", plain_o, 128'h0);
        chk(tag_o === '0, "reset_tag", tag_o, 128'h0);
        chk(auth_ok_o === 1'b0, "reset_auth", 128'(auth_ok_o), 128'h0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic goto(input int e);
    while (cyc < e) tick();
  endtask

  // Present a block so that it is sampled at edge e
  task automatic pulse_valid(input int e, input logic [127:0] d, input bit last, input logic [4:0] nb);
    goto(e - 1);
    data_i = d; data_valid_i = 1'b1; data_last_i = last; data_bytes_i = nb;
    tick();
    data_valid_i = 1'b0; data_last_i = 1'b0;
  endtask

  task automatic pulse_junk(input int e);
    pulse_valid(e, rnd128(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 16)));
  endtask

  task automatic pulse_start(input int e);
    goto(e - 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic apply_reset(input int e, input int len);
    goto(e - 1);
    reset_i = 1'b1;
    repeat (len) tick();
    reset_i = 1'b0;
    pq.delete();
    end_cyc = BIG;
    rst_cyc = cyc;
  endtask

  function automatic int gap_of(input int mode);
    case (mode)
      0: return 0;
      1: return 1;
      2: return 50;
      default: begin
        int r;
        r = int'($urandom_range(0, 3));
        return (r == 3) ? 50 : ((r == 2) ? 1 : 0);
      end
    endcase
  endfunction

  task automatic run_msg(input int gapmode, input bit misuse, input bit tamper, input bit abort);
    int e0, nxt, acc;
    bit last;
    exp_t ex;
    model_encrypt();
    key_i = cur_key;
    nonce_i = cur_nonce;
    tag_i = tamper ? (m_tag ^ 128'h1) : m_tag;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    end_cyc = BIG;
    e0 = cyc;
    if (misuse) pulse_junk(e0 + 1 + int'($urandom_range(0, 11)));
    nxt = e0 + 13;
    for (int i = 0; i < n_ad; i++) begin
      acc = nxt + gap_of(gapmode);
      pulse_valid(acc, ad_blk[i], i == n_ad - 1, 5'($urandom_range(0, 31)));
      nxt = acc + 9;
      if (misuse) pulse_junk(acc + 1 + int'($urandom_range(0, 7)));
    end
    for (int i = 0; i < n_ct; i++) begin
      last = (i == n_ct - 1);
      acc = nxt + gap_of(gapmode);
      ex.c = acc;
      ex.d = exp_pt[i];
      pq.push_back(ex);
      pulse_valid(acc, ct_blk[i], last, last ? 5'(last_len) : 5'($urandom_range(0, 31)));
      nxt = acc + 9;
      if (!last) begin
        if (abort) begin
          apply_reset(acc + 1 + int'($urandom_range(0, 7)), 1);
          goto(cyc + 3);
          return;
        end
        if (misuse) begin
          pulse_junk(acc + 1 + int'($urandom_range(0, 3)));
          pulse_start(acc + 5 + int'($urandom_range(0, 3)));
        end
      end else begin
        exp_tag = m_tag;
        exp_auth = !tamper;
        end_cyc = acc + 12;
        if (misuse) pulse_junk(acc + 1 + int'($urandom_range(0, 11)));
        goto(acc + 15);
      end
    end
  endtask

  task automatic set_nominal();
    cur_key = 128'h691AED630E81901F6CB10AD9CA912F80;
    cur_nonce = 128'h46487B3E06D9D7A80C4C36A20853217C;
    n_ad = 1;
    ad_blk[0] = 128'h00000001626F42206F74206563696C41;
    n_ct = 3;
    pt_blk[0] = 128'h6f77206f6c6c6548_2021646c726f7720;
    pt_blk[1] = 128'h7365676173736520_746572636573206d;
    pt_blk[2] = 128'h0065756c61762065_7079742065736c61;
    last_len = 15;
  endtask

  task automatic set_random();
    cur_key = rnd128();
    cur_nonce = rnd128();
    n_ad = int'($urandom_range(1, 3));
    n_ct = int'($urandom_range(1, 4));
    for (int i = 0; i < 4; i++) begin
      ad_blk[i] = rnd128();
      pt_blk[i] = rnd128();
    end
    last_len = int'($urandom_range(0, 16));
  endtask

  initial begin
    apply_reset(1, 3);
    goto(cyc + 2);

    set_nominal();
    run_msg(0, 1'b0, 1'b0, 1'b0);
    run_msg(0, 1'b0, 1'b1, 1'b0);
    run_msg(1, 1'b0, 1'b0, 1'b0);
    run_msg(2, 1'b0, 1'b0, 1'b0);
    run_msg(3, 1'b0, 1'b0, 1'b0);
    run_msg(0, 1'b1, 1'b0, 1'b0);
    run_msg(0, 1'b0, 1'b0, 1'b1);
    run_msg(0, 1'b0, 1'b0, 1'b0);

    // Full block followed by an empty final block, then a 16-byte final block
    set_random();
    n_ct = 2;
    last_len = 0;
    run_msg(0, 1'b0, 1'b0, 1'b0);
    set_random();
    last_len = 16;
    run_msg(3, 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      set_random();
      run_msg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), 1'b0);
    end

    goto(cyc + 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
